// File: rtl/pneumatic_sequencer_if.sv
// Board-side signal bundle for the pneumatic sequencer: raw buttons, mode level,
// limit sensors, valve commands and status.
interface pneumatic_sequencer_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             START_BUTTON;
  logic             STOP_REANUDAR_BUTTON;
  logic             CONTINUO;
  logic             a0;
  logic             a1;
  logic             b0;
  logic             b1;
  logic             Ap;
  logic             Bp;
  logic             Am;
  logic             Bm;
  logic [2:0]       STEP;
  logic             BUSY;
  logic             FAULT;
  logic [CNT_W-1:0] CYCLES;

  modport master (
    output START_BUTTON, STOP_REANUDAR_BUTTON, CONTINUO, a0, a1, b0, b1,
    input  Ap, Bp, Am, Bm, STEP, BUSY, FAULT, CYCLES
  );

  modport slave (
    input  START_BUTTON, STOP_REANUDAR_BUTTON, CONTINUO, a0, a1, b0, b1,
    output Ap, Bp, Am, Bm, STEP, BUSY, FAULT, CYCLES
  );
endinterface

// File: rtl/pneumatic_sequencer.sv
// A+ B+ A- B- cascade controller: synchronized/debounced inputs, single or continuous
// cycling, pause/resume, per-step watchdog, sensor-conflict fault and cycle counter.
module pneumatic_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_TIMEOUT    = 1000000,
  parameter int unsigned CNT_W           = 8
) (
  input logic                  CLK,
  input logic                  RESET,
  pneumatic_sequencer_if.slave bus
);
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned WdW = $clog2(STEP_TIMEOUT);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StAPlus  = 3'd1;
  localparam logic [2:0] StBPlus  = 3'd2;
  localparam logic [2:0] StAMinus = 3'd3;
  localparam logic [2:0] StBMinus = 3'd4;
  localparam logic [2:0] StPause  = 3'd5;
  localparam logic [2:0] StFault  = 3'd6;

  // Bit order: start, stop, continuo, a0, a1, b0, b1; buttons idle high.
  localparam logic [6:0] SyncRst = 7'b000_0011;

  logic [6:0] raw, sync1_q, sync2_q;
  assign raw = {bus.b1, bus.b0, bus.a1, bus.a0, bus.CONTINUO,
                bus.STOP_REANUDAR_BUTTON, bus.START_BUTTON};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1_q <= SyncRst;
      sync2_q <= SyncRst;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  logic cont, a0, a1, b0, b1;
  assign cont = sync2_q[2];
  assign a0   = sync2_q[3];
  assign a1   = sync2_q[4];
  assign b0   = sync2_q[5];
  assign b1   = sync2_q[6];

  logic [1:0]     flt_q, flt_prev_q;
  logic [DbW-1:0] db_cnt_q [2];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      flt_q      <= 2'b11;
      flt_prev_q <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      flt_prev_q <= flt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == flt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          flt_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Falling edge of the filtered level; held buttons never repeat.
  logic start_press, stop_press;
  assign start_press = flt_prev_q[0] & ~flt_q[0];
  assign stop_press  = flt_prev_q[1] & ~flt_q[1];

  logic [2:0]       state_q, state_d, saved_q, saved_d;
  logic [WdW-1:0]   wd_q;
  logic [CNT_W-1:0] cycles_q;
  logic             ap_q, bp_q, am_q, bm_q, busy_q, fault_q;
  logic             motion, motion_d, exit_seen, conflict, timeout, cyc_inc;

  assign motion   = state_q inside {StAPlus, StBPlus, StAMinus, StBMinus};
  assign motion_d = state_d inside {StAPlus, StBPlus, StAMinus, StBMinus};
  assign conflict = (a0 & a1) | (b0 & b1);
  assign timeout  = motion && (wd_q == WdW'(STEP_TIMEOUT - 1));

  always_comb begin
    exit_seen = 1'b0;
    case (state_q)
      StAPlus:  exit_seen = a1;
      StBPlus:  exit_seen = b1;
      StAMinus: exit_seen = a0;
      StBMinus: exit_seen = b0;
      default:  exit_seen = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cyc_inc = 1'b0;
    if (state_q != StFault && conflict) begin
      state_d = StFault;
    end else if (timeout) begin
      state_d = StFault;
    end else if (stop_press && motion) begin
      state_d = StPause;
      saved_d = state_q;
    end else if (stop_press && state_q == StPause) begin
      state_d = saved_q;
    end else if (motion && exit_seen) begin
      if (state_q == StBMinus) begin
        cyc_inc = 1'b1;
        state_d = cont ? StAPlus : StIdle;
      end else begin
        state_d = state_q + 3'd1;
      end
    end else if (state_q == StIdle && start_press && a0 && b0) begin
      state_d = StAPlus;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= StIdle;
      saved_q  <= StIdle;
      wd_q     <= '0;
      cycles_q <= '0;
      ap_q     <= 1'b0;
      bp_q     <= 1'b0;
      am_q     <= 1'b0;
      bm_q     <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      cycles_q <= cycles_q + CNT_W'(cyc_inc);
      // Fresh budget on every motion entry, resume included; frozen in PAUSE.
      if (motion_d && state_d != state_q) begin
        wd_q <= '0;
      end else if (motion && state_d == state_q) begin
        wd_q <= wd_q + WdW'(1);
      end
      ap_q    <= (state_d == StAPlus);
      bp_q    <= (state_d == StBPlus);
      am_q    <= (state_d == StAMinus);
      bm_q    <= (state_d == StBMinus);
      busy_q  <= motion_d || (state_d == StPause);
      fault_q <= (state_d == StFault);
    end
  end

  assign bus.Ap     = ap_q;
  assign bus.Bp     = bp_q;
  assign bus.Am     = am_q;
  assign bus.Bm     = bm_q;
  assign bus.STEP   = state_q;
  assign bus.BUSY   = busy_q;
  assign bus.FAULT  = fault_q;
  assign bus.CYCLES = cycles_q;
endmodule

// File: tb/tb_pneumatic_sequencer.sv
// Directed-plus-random bench for pneumatic_sequencer: a cylinder model answers valve
// commands after random delays and a step/cycle model predicts every transition edge.
module tb_pneumatic_sequencer;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam int unsigned STEP_TIMEOUT    = 50;
  localparam int unsigned CNT_W           = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   exp_cycles;
  bit   cont;

  pneumatic_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pneumatic_sequencer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STEP_TIMEOUT   (STEP_TIMEOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [3:0] valves();
    return {bus.Bm, bus.Am, bus.Bp, bus.Ap};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One-edge reset with the cylinders parked home and buttons released.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.START_BUTTON = 1'b1;
    bus.STOP_REANUDAR_BUTTON = 1'b1;
    bus.a0 = 1'b1; bus.a1 = 1'b0; bus.b0 = 1'b1; bus.b1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cycles = 0;
  endtask

  task automatic press_btn(input bit s, input bit t, input int hold);
    @(posedge clk); #1;
    if (s) bus.START_BUTTON = 1'b0;
    if (t) bus.STOP_REANUDAR_BUTTON = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    bus.START_BUTTON = 1'b1;
    bus.STOP_REANUDAR_BUTTON = 1'b1;
  endtask

  // Step idx 0..3 = A+, B+, A-, B-. Cylinder leaves its start sensor, reaches the end
  // sensor dly cycles later; the valve must drop exactly 3 edges after that.
  task automatic do_step(input int idx, input int dly);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (valves() == 4'(1 << idx)) seen = 1'b1;
    end
    chk("step_entry_valves", 32'(valves()), 32'(1 << idx));
    chk("step_entry_code", 32'(bus.STEP), 32'(idx + 1));
    chk("step_busy", 32'(bus.BUSY), 32'd1);
    @(posedge clk); #1;
    case (idx)
      0:       bus.a0 = 1'b0;
      1:       bus.b0 = 1'b0;
      2:       bus.a1 = 1'b0;
      default: bus.b1 = 1'b0;
    endcase
    repeat (dly) @(posedge clk);
    #1;
    case (idx)
      0:       bus.a1 = 1'b1;
      1:       bus.b1 = 1'b1;
      2:       bus.a0 = 1'b1;
      default: bus.b0 = 1'b1;
    endcase
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("valve_held_k2", 32'(valves()), 32'(1 << idx));
    if (idx == 3) chk("cycles_before_exit", 32'(bus.CYCLES), 32'(exp_cycles));
    @(posedge clk);
    @(negedge clk);
    if (idx == 3) begin
      exp_cycles = (exp_cycles + 1) % (1 << CNT_W);
      chk("cycles_at_exit", 32'(bus.CYCLES), 32'(exp_cycles));
      chk("next_after_bminus", 32'(bus.STEP), cont ? 32'd1 : 32'd0);
    end else begin
      chk("next_step_code", 32'(bus.STEP), 32'(idx + 2));
    end
    chk("valve_off_k3", 32'((valves() >> idx) & 4'b1), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cont = 1'b0;
    exp_cycles = 0;
    rst_n = 1'b0;
    bus.START_BUTTON = 1'b1;
    bus.STOP_REANUDAR_BUTTON = 1'b1;
    bus.CONTINUO = 1'b0;
    bus.a0 = 1'b1; bus.a1 = 1'b0; bus.b0 = 1'b1; bus.b1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step", 32'(bus.STEP), 32'd0);
    chk("rst_valves", 32'(valves()), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_fault", 32'(bus.FAULT), 32'd0);
    chk("rst_cycles", 32'(bus.CYCLES), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single cycle, cylinders answer after 10 cycles.
    press_btn(1'b1, 1'b0, 6);
    for (int s = 0; s < 4; s++) do_step(s, 10);
    chk("t1_idle", 32'(bus.STEP), 32'd0);
    chk("t1_busy", 32'(bus.BUSY), 32'd0);
    chk("t1_valves", 32'(valves()), 32'd0);
    chk("t1_cycles", 32'(bus.CYCLES), 32'd1);

    // Continuous mode, 17 cycles with random response delays; mode cleared in the last.
    do_reset();
    cont = 1'b1;
    bus.CONTINUO = 1'b1;
    repeat (5) @(posedge clk);
    press_btn(1'b1, 1'b0, 6);
    for (int c = 1; c <= 17; c++) begin
      for (int s = 0; s < 4; s++) begin
        if (c == 17 && s == 1) begin
          cont = 1'b0;
          bus.CONTINUO = 1'b0;
        end
        do_step(s, int'($urandom_range(2, 12)));
      end
    end
    chk("t2_cycles_wrap", 32'(bus.CYCLES), 32'd1);
    chk("t2_idle", 32'(bus.STEP), 32'd0);
    chk("t2_busy", 32'(bus.BUSY), 32'd0);

    // Pause and resume in B_PLUS; watchdog must not run while paused.
    do_reset();
    repeat (5) @(posedge clk);
    press_btn(1'b1, 1'b0, 6);
    do_step(0, 5);
    @(posedge clk); #1;
    bus.b0 = 1'b0;
    press_btn(1'b0, 1'b1, 6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_pause_step", 32'(bus.STEP), 32'd5);
    chk("t3_pause_valves", 32'(valves()), 32'd0);
    chk("t3_pause_busy", 32'(bus.BUSY), 32'd1);
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("t3_long_pause_fault", 32'(bus.FAULT), 32'd0);
    chk("t3_long_pause_step", 32'(bus.STEP), 32'd5);
    press_btn(1'b0, 1'b1, 6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t3_resume_step", 32'(bus.STEP), 32'd2);
    chk("t3_resume_valves", 32'(valves()), 32'b0010);
    for (int s = 1; s < 4; s++) do_step(s, 5);
    chk("t3_cycles", 32'(bus.CYCLES), 32'd1);

    // Watchdog in A_MINUS: a0 never returns; FAULT exactly STEP_TIMEOUT edges after entry.
    repeat (10) @(posedge clk);
    press_btn(1'b1, 1'b0, 6);
    do_step(0, 4);
    do_step(1, 4);
    @(posedge clk); #1;
    bus.a1 = 1'b0;
    repeat (STEP_TIMEOUT - 2) @(posedge clk);
    @(negedge clk);
    chk("t4_before_timeout", 32'(bus.STEP), 32'd3);
    @(posedge clk);
    @(negedge clk);
    chk("t4_timeout_fault", 32'(bus.FAULT), 32'd1);
    chk("t4_timeout_step", 32'(bus.STEP), 32'd6);
    chk("t4_timeout_valves", 32'(valves()), 32'd0);
    press_btn(1'b1, 1'b1, 6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t4_fault_sticky", 32'(bus.STEP), 32'd6);
    do_reset();
    @(negedge clk);
    chk("t4_rst_step", 32'(bus.STEP), 32'd0);
    chk("t4_rst_fault", 32'(bus.FAULT), 32'd0);
    chk("t4_rst_cycles", 32'(bus.CYCLES), 32'd0);
    chk("t4_rst_busy", 32'(bus.BUSY), 32'd0);

    // Debounce: a 3-sample glitch is rejected; a held press lands 7 edges after going low.
    repeat (10) @(posedge clk);
    press_btn(1'b1, 1'b0, 3);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t5_glitch_ignored", 32'(bus.STEP), 32'd0);
    @(posedge clk); #1;
    bus.START_BUTTON = 1'b0;
    repeat (DEBOUNCE_CYCLES + 2) @(posedge clk);
    @(negedge clk);
    chk("t5_press_early", 32'(bus.STEP), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_press_exact", 32'(bus.STEP), 32'd1);
    chk("t5_press_ap", 32'(valves()), 32'b0001);
    @(posedge clk); #1;
    bus.START_BUTTON = 1'b1;
    for (int s = 0; s < 4; s++) do_step(s, int'($urandom_range(2, 12)));
    @(posedge clk); #1;
    bus.a0 = 1'b0;
    bus.a1 = 1'b1;
    repeat (5) @(posedge clk);
    press_btn(1'b1, 1'b0, 6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t5_not_home_ignored", 32'(bus.STEP), 32'd0);
    chk("t5_not_home_busy", 32'(bus.BUSY), 32'd0);

    // Sensor conflict in IDLE, then reset in the middle of B_MINUS.
    @(posedge clk); #1;
    bus.a0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_conflict_k2", 32'(bus.FAULT), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_conflict_fault", 32'(bus.FAULT), 32'd1);
    chk("t6_conflict_step", 32'(bus.STEP), 32'd6);
    do_reset();
    @(negedge clk);
    chk("t6_rst_fault", 32'(bus.FAULT), 32'd0);
    repeat (5) @(posedge clk);
    press_btn(1'b1, 1'b0, 6);
    for (int s = 0; s < 4; s++) do_step(s, int'($urandom_range(2, 12)));
    repeat (10) @(posedge clk);
    press_btn(1'b1, 1'b0, 6);
    for (int s = 0; s < 3; s++) do_step(s, int'($urandom_range(2, 12)));
    chk("t6_in_bminus", 32'(valves()), 32'b1000);
    chk("t6_cycles_pre_rst", 32'(bus.CYCLES), 32'd1);
    do_reset();
    @(negedge clk);
    chk("t6_rst_valves", 32'(valves()), 32'd0);
    chk("t6_rst_step", 32'(bus.STEP), 32'd0);
    chk("t6_rst_cycles", 32'(bus.CYCLES), 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_no_resume", 32'(bus.STEP), 32'd0);
    chk("t6_no_resume_busy", 32'(bus.BUSY), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pneumatic_sequencer.md
# pneumatic_sequencer

Cycle controller for the four-slot A+ B+ A- B- electropneumatic cascade. Takes the raw start and stop/resume buttons plus the four limit sensors (a0, a1, b0, b1) and drives the four valve commands (Ap, Bp, Am, Bm) in strict order. It adds:
- button debouncing;
- single-cycle and continuous modes;
- pause/resume;
- per-step watchdog timeout and sensor-conflict fault;
- a completed-cycle counter.

It sits between the board I/O and the valve drivers, replacing hand-wired slot sequencing.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable samples required to accept a button level change (≥2).
- STEP_TIMEOUT, 1000000: maximum cycles allowed in one motion step before FAULT (≥2).
- CNT_W, 8: width of the completed-cycle counter.

- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-low; one clock; sampled on CLK rising edge.
- START_BUTTON  in  1  raw, active-low, asynchronous.
- STOP_REANUDAR_BUTTON  in  1  raw, active-low, asynchronous; stop/resume toggle.
- CONTINUO  in  1  1 = repeat cycles, 0 = single cycle; level, asynchronous.
- a0, a1, b0, b1  in  1 each  limit sensors, active-high, asynchronous (a0/b0 retracted, a1/b1 extended).
- Ap, Bp, Am, Bm  out  1 each  valve commands, registered.
- STEP  out  3  current state code.
- BUSY  out  1  1 in any motion state or PAUSE.
- FAULT  out  1  1 in FAULT state.
- CYCLES  out  CNT_W  completed cycles, wraps.

## Operation
- Input conditioning:
  - Every async input passes through a 2-FF synchronizer.
  - The buttons additionally pass a debouncer: the filtered level changes only after DEBOUNCE_CYCLES consecutive synchronized samples at the new level.
  - A press is a one-cycle pulse on a filtered 1→0 transition.
- STEP codes: 0 IDLE, 1 A_PLUS, 2 B_PLUS, 3 A_MINUS, 4 B_MINUS, 5 PAUSE, 6 FAULT.
- Outputs by state:
  - Ap=1 only in A_PLUS; Bp=1 only in B_PLUS; Am=1 only in A_MINUS; Bm=1 only in B_MINUS.
  - All valve outputs are 0 in IDLE, PAUSE and FAULT.
- Transitions:
  - IDLE → A_PLUS on start press when a0 & b0 (home). The press is ignored if not home.
  - A_PLUS → B_PLUS on a1.
  - B_PLUS → A_MINUS on b1.
  - A_MINUS → B_MINUS on a0.
  - B_MINUS, on b0: CYCLES increments (wraps at 2^CNT_W). Then A_PLUS if CONTINUO=1, else IDLE.
  - CONTINUO is sampled only at cycle completion; clearing it mid-cycle finishes the current cycle.
- Pause:
  - A stop press in a motion state goes to PAUSE and saves the step.
  - A stop press in PAUSE resumes the saved step.
  - A stop press in IDLE or FAULT is ignored.
  - A start press in PAUSE is ignored.
- Watchdog:
  - The counter clears on every entry to a motion state, including resume, and counts while in that state.
  - On reaching STEP_TIMEOUT-1 without the exit sensor, the next state is FAULT.
  - The counter is frozen in PAUSE.
- Sensor conflict: (a0 & a1) or (b0 & b1) in any state except FAULT → FAULT.
- FAULT is exited only by RESET.
- Priority in one cycle: conflict > timeout > stop press > sensor advance > start press.
- Start and stop pressed in the same cycle in IDLE: start is honoured.

## Timing
- Reset values: Ap=Bp=Am=Bm=0, STEP=0, BUSY=0, FAULT=0, CYCLES=0. Synchronizers and filtered button levels reset to released (1). Watchdog reset to 0.
- RESET asserted mid-cycle: all outputs go to reset values on that edge; no motion resumes after release.
- Sensor latency: a sensor high at edge k produces the state change, and the output change, at edge k+3 (2 sync + 1 FSM register).
- Button latency: a button held low from edge k produces the state change at edge k+2+DEBOUNCE_CYCLES+1.
- A press pulse lasts exactly one cycle. Holding a button produces no repeat presses.
- Timeout: a step entered at edge e goes to FAULT at edge e+STEP_TIMEOUT if the exit sensor is never seen.
- CYCLES updates on the same edge as the B_MINUS exit.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, STEP_TIMEOUT=50, CNT_W=4.
1. Single cycle: home, CONTINUO=0, start press, cylinder model answers each command after 10 cycles → outputs Ap, Bp, Am, Bm in order, each 1 until 3 cycles after its sensor; then IDLE, CYCLES=1, BUSY=0.
2. Continuous mode with 17 cycles, CONTINUO cleared during cycle 17 → CYCLES wraps to 1; state returns to IDLE after cycle 17 completes.
3. Pause/resume in B_PLUS: stop press → STEP=5 and all outputs 0. Hold 200 cycles → no FAULT. Second stop press → STEP=2 and Bp=1 again.
4. Timeout: in A_MINUS, never assert a0 → FAULT=1, STEP=6 exactly 50 cycles after entry. Start and stop presses have no effect; RESET low for one edge → all reset values.
5. Debounce: start button glitches low for 3 cycles → no start; held low for 4+ cycles → A_PLUS at exactly 7 cycles after the first low edge. Not home (a1=1) → start ignored.
6. Conflict and reset: a0=a1=1 while in IDLE → FAULT within 3 cycles. RESET during B_MINUS → outputs 0 and CYCLES=0.
